control_ranas_multi: RTL and testbench

//  Frog-lifecycle controller for the JUEGO level: N home slots, lives counter, respawn timing, win/game-over.

---
 rtl/control_ranas_multi.sv | 188 ++++++++++++++++++
 tb/tb_control_ranas_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_ranas_multi.sv
// -----------------------------------------------------------------------------
// control_ranas_multi
//
// Frog-lifecycle controller for the JUEGO level. It tracks which of the
// NUM_CASAS home slots are occupied, counts remaining lives, holds the frog at
// its start position for a fixed number of cycles after every respawn event,
// and reports level-won / game-over.
//
// Ports
//   CRM_CLOCK_50       in   system clock
//   CRM_RESET          in   synchronous, active-high reset
//   CRM_POSX_IN        in   frog column (home slot index when on the home row)
//   CRM_POSY_IN        in   frog row
//   CRM_PERDIO_IN      in   collision/drown flag, sampled every cycle
//   CRM_ESTADO_IN      in   game-state code from the top-level game FSM
//   CRM_RANA_INI_OUT   out  1 = force frog back to its start position
//   CRM_GANO_OUT       out  1 = every home slot is filled
//   CRM_GAME_OVER_OUT  out  1 = lives exhausted
//   CRM_CASAS_OUT      out  occupied-home bitmask, bit i = slot i
//   CRM_VIDAS_OUT      out  remaining lives
//
// Build option
//   CR_VIDA_EXTRA_EN   when defined, winning a level awards one extra life
//                      (saturating at the counter maximum).
// -----------------------------------------------------------------------------
module control_ranas_multi #(
  parameter int                          DATAWIDTH_ESTADO = 3,
  parameter int                          DATAWIDTH_POS    = 3,
  parameter int                          NUM_CASAS        = 4,
  parameter int                          POSY_META        = 0,
  parameter int                          DATAWIDTH_VIDAS  = 2,
  parameter int                          VIDAS_INI        = 3,
  parameter int                          RESPAWN_CYCLES   = 4,
  parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_JUEGO     = 3'b010,
  parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_INICIO    = 3'b001
) (
  input  logic                        CRM_CLOCK_50,
  input  logic                        CRM_RESET,
  input  logic [DATAWIDTH_POS-1:0]    CRM_POSX_IN,
  input  logic [DATAWIDTH_POS-1:0]    CRM_POSY_IN,
  input  logic                        CRM_PERDIO_IN,
  input  logic [DATAWIDTH_ESTADO-1:0] CRM_ESTADO_IN,
  output logic                        CRM_RANA_INI_OUT,
  output logic                        CRM_GANO_OUT,
  output logic                        CRM_GAME_OVER_OUT,
  output logic [NUM_CASAS-1:0]        CRM_CASAS_OUT,
  output logic [DATAWIDTH_VIDAS-1:0]  CRM_VIDAS_OUT
);

  localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]           CNT_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [DATAWIDTH_VIDAS-1:0] VIDAS_LOAD = DATAWIDTH_VIDAS'(VIDAS_INI);
  localparam logic [DATAWIDTH_VIDAS-1:0] VIDAS_ONE  = DATAWIDTH_VIDAS'(1);
  localparam logic [DATAWIDTH_POS-1:0]   META_ROW   = DATAWIDTH_POS'(POSY_META);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_RESPAWN = 3'd2,
    S_WIN     = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_CASAS-1:0]         casas_q, casas_d;
  logic [DATAWIDTH_VIDAS-1:0]   vidas_q, vidas_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         rana_ini_q, gano_q, game_over_q;

  logic                         juego;
  logic                         inicio;
  logic                         at_meta;
  logic [NUM_CASAS-1:0]         slot_hit;
  logic [NUM_CASAS-1:0]         casas_set;
  logic                         arrival_ok;
  logic                         lose;

  assign juego   = (CRM_ESTADO_IN == ESTADO_JUEGO);
  assign inicio  = (CRM_ESTADO_IN == ESTADO_INICIO);
  assign at_meta = (CRM_POSY_IN == META_ROW);

  // One-hot decode of the column onto the home slots. A column beyond the
  // last slot decodes to all zeros, so it naturally counts as a bad landing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CASAS; gi++) begin : g_slot
      assign slot_hit[gi] = (CRM_POSX_IN == DATAWIDTH_POS'(gi));
    end
  endgenerate

  assign casas_set  = casas_q | slot_hit;
  assign arrival_ok = |(slot_hit & ~casas_q);

  // Collision wins over a simultaneous arrival; a landing on an occupied or
  // non-existent slot is treated as a loss as well.
  assign lose = CRM_PERDIO_IN || (at_meta && !arrival_ok);

  always_comb begin
    state_d = state_q;
    casas_d = casas_q;
    vidas_d = vidas_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (juego) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Any ESTADO other than JUEGO pauses the level with everything held.
        if (juego) begin
          if (lose) begin
            if (vidas_q <= VIDAS_ONE) begin
              vidas_d = '0;
              state_d = S_OVER;
            end else begin
              vidas_d = vidas_q - VIDAS_ONE;
              state_d = S_RESPAWN;
              cnt_d   = CNT_LOAD;
            end
          end else if (at_meta) begin
            casas_d = casas_set;
            if (&casas_set) begin
              state_d = S_WIN;
`ifdef CR_VIDA_EXTRA_EN
              if (vidas_q != '1) vidas_d = vidas_q + VIDAS_ONE;
`endif
            end else begin
              state_d = S_RESPAWN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
      end
      S_RESPAWN: begin
        // Counter runs RESPAWN_CYCLES-1 down to 0, giving exactly
        // RESPAWN_CYCLES cycles in this state; pausing freezes it.
        if (juego) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_WIN: begin
        // Next level: homes cleared, lives carried over.
        if (inicio) begin
          state_d = S_IDLE;
          casas_d = '0;
        end
      end
      S_OVER: begin
        if (inicio) begin
          state_d = S_IDLE;
          casas_d = '0;
          vidas_d = VIDAS_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CRM_CLOCK_50) begin
    if (CRM_RESET) begin
      state_q     <= S_IDLE;
      casas_q     <= '0;
      vidas_q     <= VIDAS_LOAD;
      cnt_q       <= '0;
      rana_ini_q  <= 1'b1;
      gano_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      casas_q     <= casas_d;
      vidas_q     <= vidas_d;
      cnt_q       <= cnt_d;
      // Flags are registered from the next state so they line up with it.
      rana_ini_q  <= (state_d == S_IDLE) || (state_d == S_RESPAWN);
      gano_q      <= (state_d == S_WIN);
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign CRM_RANA_INI_OUT  = rana_ini_q;
  assign CRM_GANO_OUT      = gano_q;
  assign CRM_GAME_OVER_OUT = game_over_q;
  assign CRM_CASAS_OUT     = casas_q;
  assign CRM_VIDAS_OUT     = vidas_q;

endmodule

// File: tb/tb_control_ranas_multi.sv
// -----------------------------------------------------------------------------
// tb_control_ranas_multi
//
// Self-checking bench for control_ranas_multi (default parameters). Directed
// scenarios followed by a randomized run, all checked cycle by cycle against
// a behavioural model of the frog lifecycle, plus explicit constant checks at
// the key scenario points.
// -----------------------------------------------------------------------------
module tb_control_ranas_multi;

  localparam logic [2:0] JUEGO  = 3'b010;
  localparam logic [2:0] INICIO = 3'b001;
  localparam logic [2:0] PAUSA  = 3'b100;
  localparam logic [2:0] META   = 3'd0;
  localparam logic [2:0] AWAY   = 3'd5;
  localparam int         NCASAS = 4;
  localparam int         VINI   = 3;
  localparam int         VMAX   = 3;
  localparam int         RCYC   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] posx, posy, estado;
  logic       perdio;
  logic       rana_ini, gano, game_over;
  logic [3:0] casas;
  logic [1:0] vidas;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  // Behavioural model of the game as the player sees it.
  bit       m_idle, m_won, m_over;
  int       m_left;   // respawn cycles still to show, 0 = frog is free
  int       m_vidas;
  bit [3:0] m_casas;

  always #5 clk = ~clk;

  control_ranas_multi dut (
    .CRM_CLOCK_50      (clk),
    .CRM_RESET         (rst),
    .CRM_POSX_IN       (posx),
    .CRM_POSY_IN       (posy),
    .CRM_PERDIO_IN     (perdio),
    .CRM_ESTADO_IN     (estado),
    .CRM_RANA_INI_OUT  (rana_ini),
    .CRM_GANO_OUT      (gano),
    .CRM_GAME_OVER_OUT (game_over),
    .CRM_CASAS_OUT     (casas),
    .CRM_VIDAS_OUT     (vidas)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, stepno);
    end
  endtask

  task automatic lose_life();
    if (m_vidas <= 1) begin
      m_vidas = 0;
      m_over  = 1;
    end else begin
      m_vidas = m_vidas - 1;
      m_left  = RCYC;
    end
  endtask

  task automatic model_update(input logic r, input logic [2:0] est,
                              input logic [2:0] px, input logic [2:0] py, input logic per);
    if (r) begin
      m_idle = 1; m_won = 0; m_over = 0; m_left = 0;
      m_casas = '0; m_vidas = VINI;
    end else if (m_idle) begin
      if (est == JUEGO) m_idle = 0;
    end else if (m_won) begin
      if (est == INICIO) begin m_won = 0; m_idle = 1; m_casas = '0; end
    end else if (m_over) begin
      if (est == INICIO) begin m_over = 0; m_idle = 1; m_casas = '0; m_vidas = VINI; end
    end else if (est == JUEGO) begin
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (per) begin
        lose_life();
      end else if (py == META) begin
        if (int'(px) >= NCASAS || m_casas[px[1:0]]) begin
          lose_life();
        end else begin
          m_casas[px[1:0]] = 1'b1;
          if (m_casas == 4'hF) begin
            m_won = 1;
`ifdef CR_VIDA_EXTRA_EN
            if (m_vidas < VMAX) m_vidas = m_vidas + 1;
`endif
          end else begin
            m_left = RCYC;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] est,
                      input logic [2:0] px, input logic [2:0] py, input logic per);
    rst = r; estado = est; posx = px; posy = py; perdio = per;
    @(posedge clk);
    model_update(r, est, px, py, per);
    #1;
    stepno++;
    $display("step %0d rst=%0b est=%0d x=%0d y=%0d perdio=%0b -> rana=%0b gano=%0b over=%0b casas=%b vidas=%0d",
             stepno, r, est, px, py, per, rana_ini, gano, game_over, casas, vidas);
    check("rana_ini",  32'(rana_ini),  32'(m_idle || (m_left > 0)));
    check("gano",      32'(gano),      32'(m_won));
    check("game_over", 32'(game_over), 32'(m_over));
    check("casas",     32'(casas),     32'(m_casas));
    check("vidas",     32'(vidas),     32'(m_vidas));
  endtask

  // Land on slot x, then sit out the respawn hold away from the home row.
  task automatic arrive(input logic [2:0] x, output int rana_cycles);
    rana_cycles = 0;
    step(0, JUEGO, x, META, 0);
    if (rana_ini) rana_cycles++;
    for (int k = 0; k < RCYC; k++) begin
      step(0, JUEGO, 3'd0, AWAY, 0);
      if (rana_ini) rana_cycles++;
    end
  endtask

  task automatic hit(input int waits);
    step(0, JUEGO, 3'd0, AWAY, 1);
    for (int k = 0; k < waits; k++) step(0, JUEGO, 3'd0, AWAY, 0);
  endtask

  task automatic fresh_start();
    step(1, 3'd0, 3'd0, AWAY, 0);
    step(0, JUEGO, 3'd0, AWAY, 0);
  endtask

  initial begin
    int rc;
    rst = 1; estado = '0; posx = '0; posy = AWAY; perdio = 0;
    m_idle = 1; m_won = 0; m_over = 0; m_left = 0; m_casas = '0; m_vidas = VINI;

    // Reset state
    step(1, 3'd0, 3'd0, AWAY, 0);
    check("reset_rana",  32'(rana_ini), 32'd1);
    check("reset_vidas", 32'(vidas),    32'd3);
    check("reset_casas", 32'(casas),    32'd0);

    // 1: single arrival on slot 2, respawn hold length
    step(0, JUEGO, 3'd0, AWAY, 0);
    check("play_rana", 32'(rana_ini), 32'd0);
    arrive(3'd2, rc);
    check("t1_casas",       32'(casas), 32'h4);
    check("t1_rana_cycles", 32'(rc),    32'(RCYC));
    check("t1_vidas",       32'(vidas), 32'd3);

    // 2: fill every slot in order, then restart into the next level
    fresh_start();
    for (int s = 0; s < 3; s++) arrive(3'(s), rc);
    step(0, JUEGO, 3'd3, META, 0);
    check("t2_gano",  32'(gano),  32'd1);
    check("t2_casas", 32'(casas), 32'hF);
    step(0, JUEGO, 3'd0, AWAY, 0);
    check("t2_win_hold", 32'(casas), 32'hF);
    step(0, INICIO, 3'd0, AWAY, 0);
    check("t2_restart_casas", 32'(casas), 32'd0);
    check("t2_restart_vidas", 32'(vidas), 32'd3);
    check("t2_restart_gano",  32'(gano),  32'd0);

    // 3: three losses to game over, then restart
    fresh_start();
    hit(RCYC);
    check("t3_vidas2", 32'(vidas), 32'd2);
    hit(RCYC);
    check("t3_vidas1", 32'(vidas), 32'd1);
    step(0, JUEGO, 3'd0, AWAY, 1);
    check("t3_vidas0", 32'(vidas),     32'd0);
    check("t3_over",   32'(game_over), 32'd1);
    step(0, INICIO, 3'd0, AWAY, 0);
    check("t3_restart_vidas", 32'(vidas),     32'd3);
    check("t3_restart_over",  32'(game_over), 32'd0);

    // 4: collision beats arrival; occupied slot and out-of-range column lose
    fresh_start();
    step(0, JUEGO, 3'd1, META, 1);
    check("t4_both_vidas", 32'(vidas), 32'd2);
    check("t4_both_casas", 32'(casas), 32'd0);
    for (int k = 0; k < RCYC; k++) step(0, JUEGO, 3'd0, AWAY, 0);
    arrive(3'd0, rc);
    step(0, JUEGO, 3'd0, META, 0);
    check("t4_occupied_vidas", 32'(vidas), 32'd1);
    check("t4_occupied_casas", 32'(casas), 32'd1);
    for (int k = 0; k < RCYC; k++) step(0, JUEGO, 3'd0, AWAY, 0);
    step(0, JUEGO, 3'd5, META, 0);
    check("t4_posx5_over", 32'(game_over), 32'd1);

    // 5: pause in the middle of a respawn hold
    fresh_start();
    step(0, JUEGO, 3'd3, META, 0);
    step(0, JUEGO, 3'd0, AWAY, 0);
    rc = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, PAUSA, 3'd0, AWAY, 0);
      if (rana_ini) rc++;
    end
    check("t5_frozen_rana", 32'(rc), 32'd10);
    rc = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, JUEGO, 3'd0, AWAY, 0);
      if (rana_ini) rc++;
    end
    check("t5_resume_cycles", 32'(rc), 32'd2);

    // 6: reset during a respawn hold with two homes filled
    fresh_start();
    arrive(3'd0, rc);
    step(0, JUEGO, 3'd1, META, 0);
    step(0, JUEGO, 3'd0, AWAY, 0);
    check("t6_pre_casas", 32'(casas), 32'h3);
    step(1, JUEGO, 3'd0, AWAY, 0);
    check("t6_rst_casas", 32'(casas),     32'd0);
    check("t6_rst_rana",  32'(rana_ini),  32'd1);
    check("t6_rst_vidas", 32'(vidas),     32'd3);
    check("t6_rst_over",  32'(game_over), 32'd0);

    // Randomized play against the model
    for (int n = 0; n < 600; n++) begin
      logic       r, p;
      logic [2:0] e, x, y;
      int         sel;
      r   = ($urandom_range(0, 99) < 2);
      sel = $urandom_range(0, 99);
      e   = (sel < 80) ? JUEGO : (sel < 90) ? INICIO : 3'($urandom_range(0, 7));
      x   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      y   = ($urandom_range(0, 2) == 0) ? META : 3'($urandom_range(0, 7));
      p   = ($urandom_range(0, 99) < 8);
      step(r, e, x, y, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
